iob_eth_rx_ctrl: RTL
====================

# iob_eth_rx_ctrl

Receive-side buffer controller between the MII receiver (`iob_eth_rx`) and the frame-buffer RAM. It steers each incoming frame into one of NSLOTS buffer slots and filters it by destination MAC and CRC status. It acknowledges the receiver and queues accepted frames to the consumer (DMA or CPU) as descriptors, until the consumer releases each slot. This lets the receiver accept back-to-back frames without waiting for software.

## Interface
- NSLOTS, 2: number of frame slots; power of 2, range 2..4; SLOT_W = log2(NSLOTS).
- ADDR_W, 11: per-slot byte-address width; a slot holds 2^ADDR_W bytes.
- CNT_W, 16: width of the statistics counters.
- rx_clk_i  in  1  clock (the MII receive clock domain).
- arst_i  in  1  reset, asynchronous, active-high.
- cfg_mac_addr_i  in  48  station MAC; byte 0 is bits [47:40].
- cfg_promisc_i  in  1  accept any destination MAC.
- cfg_bcast_en_i  in  1  accept FF:FF:FF:FF:FF:FF.
- cfg_drop_crc_i  in  1  drop frames with CRC error.
- rx_wr_i  in  1  byte write strobe from the receiver.
- rx_addr_i  in  ADDR_W  byte address within the frame.
- rx_data_i  in  8  byte data.
- rx_data_rcvd_i  in  1  frame-complete level from the receiver.
- rx_crc_err_i  in  1  CRC-error level from the receiver.
- rx_rcv_ack_o  out  1  one-cycle acknowledge to the receiver.
- buf_wr_o  out  1  RAM write enable.
- buf_addr_o  out  SLOT_W+ADDR_W  RAM address {slot, byte}.
- buf_data_o  out  8  RAM write data.
- desc_valid_o  out  1  descriptor available.
- desc_ready_i  in  1  consumer accepts the descriptor.
- desc_slot_o  out  SLOT_W  slot holding the frame.
- desc_len_o  out  ADDR_W+1  frame length in bytes, including FCS.
- desc_crc_err_o  out  1  CRC-error flag; only possible when cfg_drop_crc_i=0.
- release_i  in  1  pulse: free the oldest presented slot.
- frames_ok_o  out  CNT_W  accepted-frame count; saturates at all-ones.
- frames_drop_o  out  CNT_W  dropped-frame count (filter, CRC or overflow); saturates at all-ones.

## Operation
- Slot ring pointers:
  - wr_ptr: slot currently being filled.
  - dsc_ptr: next slot to present as a descriptor.
  - rel_ptr: oldest slot not yet released.
- Counters:
  - n_full: accepted slots not yet presented.
  - n_used: accepted slots not yet released.
  - All pointers wrap modulo NSLOTS.
- Write steering, every cycle:
  - If rx_wr_i=1 and n_used<NSLOTS: register buf_wr_o=1, buf_addr_o={wr_ptr, rx_addr_i} and buf_data_o=rx_data_i.
  - If rx_wr_i=1 and n_used=NSLOTS: buf_wr_o=0 and the sticky overflow flag is set.
- Per-frame capture:
  - On writes to addresses 0..5, shift the byte into dmac.
  - len_q tracks rx_addr_i+1 of the last write.
  - overflow, dmac and len_q are cleared when the FSM enters IDLE.
- FSM states: IDLE, EVAL, ACK, WAIT_CLR.
  - IDLE: go to EVAL when rx_data_rcvd_i=1.
  - EVAL: sample rx_crc_err_i. accept = !overflow && (cfg_promisc_i || dmac==cfg_mac_addr_i || (cfg_bcast_en_i && dmac==48'hFFFF_FFFF_FFFF)) && !(cfg_drop_crc_i && rx_crc_err_i).
    - If accept: store len_q and the CRC flag in slot wr_ptr, increment wr_ptr, n_full and n_used, and increment frames_ok.
    - Otherwise: increment frames_drop.
    - Then go to ACK.
  - ACK: rx_rcv_ack_o=1 for exactly this cycle; go to WAIT_CLR.
  - WAIT_CLR: go to IDLE when rx_data_rcvd_i=0.
- Descriptor queue:
  - desc_valid_o = (n_full!=0).
  - desc_slot_o = dsc_ptr; desc_len_o and desc_crc_err_o come from slot dsc_ptr's stored values.
  - On desc_valid_o && desc_ready_i: increment dsc_ptr and decrement n_full.
- Release:
  - If release_i=1 and n_used>n_full: increment rel_ptr and decrement n_used.
  - Otherwise release_i is ignored.
- Simultaneous events:
  - Accept and pop in the same cycle: n_full unchanged.
  - Accept and release in the same cycle: n_used unchanged.
  - Pop and release in the same cycle are both legal.

## Timing
- Reset values: all outputs 0, all pointers and counters 0, FSM in IDLE.
- buf_* outputs lag rx_* inputs by exactly 1 cycle.
- rx_data_rcvd_i rising edge to rx_rcv_ack_o is exactly 2 cycles (IDLE→EVAL→ACK).
- A descriptor of an accepted frame has desc_valid_o high from the cycle after EVAL.
- Descriptor outputs hold stable while desc_valid_o=1 and desc_ready_i=0.
- Reset asserted mid-frame discards the partial frame and all slots; no ack is issued.

## Structure
- Shared package iob_eth_rx_ctrl_pkg holds:
  - FSM state encoding.
  - The broadcast MAC constant.
  - The descriptor record {len, crc_err}.
- One sub-module: iob_eth_rx_filter, a combinational MAC/CRC accept decision used in EVAL.
- The slot ring, counters and FSM stay in the top module.
- Statistics counters use the existing iob_reg with cke.

## Test plan
- MAC 02:00:00:00:00:01, 64-byte frame to that MAC with good CRC → buf writes to slot 0, ack 2 cycles after rcvd, descriptor slot 0, len 64, crc_err 0, frames_ok=1.
- Frame to 11:22:33:44:55:66 with promisc=0 → no descriptor, frames_drop=1, ack still issued.
- Broadcast frame, once with bcast_en=1 and once with bcast_en=0 → accepted, then dropped.
- CRC-bad frame → with drop_crc=1 dropped; with drop_crc=0 descriptor has crc_err=1.
- NSLOTS=2, three frames with no release → third frame produces no buf writes and is dropped. After releasing one slot, a fourth frame lands in slot 0 (wrap-around).
- Pop and release in the same cycle as an accept; arst_i pulsed mid-frame → counts consistent, and after reset all outputs are 0 and slot 0 is reused.

Source files
------------

// File: rtl/iob_eth_rx_ctrl_pkg.sv
// Shared types for the receive buffer controller: FSM encoding, broadcast
// address and the per-slot descriptor record.
package iob_eth_rx_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EVAL     = 2'd1,
    ST_ACK      = 2'd2,
    ST_WAIT_CLR = 2'd3
  } rx_state_t;

  localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

  // Length field is sized for ADDR_W=11 (2 KiB slots); widen it before
  // instantiating with larger slots.
  localparam int DESC_LEN_W = 12;

  typedef struct packed {
    logic [DESC_LEN_W-1:0] len;
    logic                  crc_err;
  } desc_t;

endpackage

// File: rtl/iob_eth_rx_filter.sv
// Combinational accept decision for a completed frame: destination MAC
// match, CRC policy and buffer overflow.
module iob_eth_rx_filter
  import iob_eth_rx_ctrl_pkg::*;
(
  input  logic [47:0] dmac_i,
  input  logic [47:0] cfg_mac_addr_i,
  input  logic        cfg_promisc_i,
  input  logic        cfg_bcast_en_i,
  input  logic        cfg_drop_crc_i,
  input  logic        crc_err_i,
  input  logic        overflow_i,
  output logic        accept_o
);

  logic mac_ok;

  assign mac_ok   = cfg_promisc_i || (dmac_i == cfg_mac_addr_i) ||
                    (cfg_bcast_en_i && (dmac_i == BCAST_MAC));
  assign accept_o = !overflow_i && mac_ok && !(cfg_drop_crc_i && crc_err_i);

endmodule

// File: rtl/iob_reg.sv
// Generic register with asynchronous active-high reset and clock enable.
module iob_reg #(
  parameter int                DATA_W  = 1,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              cke_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o
);

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      data_o <= RST_VAL;
    end else if (cke_i) begin
      data_o <= data_i;
    end
  end

endmodule

// File: rtl/iob_eth_rx_ctrl.sv
// Receive buffer controller: steers MII receiver bytes into a ring of frame
// slots, filters completed frames and queues accepted ones as descriptors.
module iob_eth_rx_ctrl
  import iob_eth_rx_ctrl_pkg::*;
#(
  parameter  int NSLOTS = 2,
  parameter  int ADDR_W = 11,
  parameter  int CNT_W  = 16,
  localparam int SLOT_W = $clog2(NSLOTS)
) (
  input  logic                     rx_clk_i,
  input  logic                     arst_i,
  input  logic [47:0]              cfg_mac_addr_i,
  input  logic                     cfg_promisc_i,
  input  logic                     cfg_bcast_en_i,
  input  logic                     cfg_drop_crc_i,
  input  logic                     rx_wr_i,
  input  logic [ADDR_W-1:0]        rx_addr_i,
  input  logic [7:0]               rx_data_i,
  input  logic                     rx_data_rcvd_i,
  input  logic                     rx_crc_err_i,
  output logic                     rx_rcv_ack_o,
  output logic                     buf_wr_o,
  output logic [SLOT_W+ADDR_W-1:0] buf_addr_o,
  output logic [7:0]               buf_data_o,
  output logic                     desc_valid_o,
  input  logic                     desc_ready_i,
  output logic [SLOT_W-1:0]        desc_slot_o,
  output logic [ADDR_W:0]          desc_len_o,
  output logic                     desc_crc_err_o,
  input  logic                     release_i,
  output logic [CNT_W-1:0]         frames_ok_o,
  output logic [CNT_W-1:0]         frames_drop_o,
  output logic [1:0]               dbg_state_o,
  output logic [SLOT_W-1:0]        dbg_rel_ptr_o
);

  rx_state_t         state, state_nxt;
  logic [SLOT_W-1:0] wr_ptr, dsc_ptr, rel_ptr;
  logic [SLOT_W:0]   n_full, n_used;
  logic              overflow_q;
  logic [47:0]       dmac_q;
  logic [ADDR_W:0]   len_q;
  desc_t             desc_mem [NSLOTS];
  logic              slot_free, enter_idle, accept, is_eval;
  logic              do_accept, do_drop, do_pop, do_rel;

  assign slot_free = n_used < (SLOT_W+1)'(NSLOTS);

  // FSM
  always_ff @(posedge rx_clk_i or posedge arst_i) begin
    if (arst_i) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    enter_idle = 1'b0;
    unique case (state)
      ST_IDLE:     if (rx_data_rcvd_i) state_nxt = ST_EVAL;
      ST_EVAL:     state_nxt = ST_ACK;
      ST_ACK:      state_nxt = ST_WAIT_CLR;
      ST_WAIT_CLR: begin
        if (!rx_data_rcvd_i) begin
          state_nxt  = ST_IDLE;
          enter_idle = 1'b1;
        end
      end
      default:     state_nxt = ST_IDLE;
    endcase
  end

  assign is_eval      = (state == ST_EVAL);
  assign rx_rcv_ack_o = (state == ST_ACK);
  assign dbg_state_o  = state;

  // A frame arriving with no free slot is rejected even if it wrote nothing,
  // so an accept can never overrun the ring.
  iob_eth_rx_filter u_filter (
    .dmac_i         (dmac_q),
    .cfg_mac_addr_i (cfg_mac_addr_i),
    .cfg_promisc_i  (cfg_promisc_i),
    .cfg_bcast_en_i (cfg_bcast_en_i),
    .cfg_drop_crc_i (cfg_drop_crc_i),
    .crc_err_i      (rx_crc_err_i),
    .overflow_i     (overflow_q || !slot_free),
    .accept_o       (accept)
  );

  assign do_accept = is_eval && accept;
  assign do_drop   = is_eval && !accept;

  // Per-frame capture
  always_ff @(posedge rx_clk_i or posedge arst_i) begin
    if (arst_i) begin
      overflow_q <= 1'b0;
      dmac_q     <= '0;
      len_q      <= '0;
    end else if (enter_idle) begin
      overflow_q <= 1'b0;
      dmac_q     <= '0;
      len_q      <= '0;
    end else if (rx_wr_i) begin
      if (!slot_free) overflow_q <= 1'b1;
      if (rx_addr_i < ADDR_W'(6)) dmac_q <= {dmac_q[39:0], rx_data_i};
      len_q <= {1'b0, rx_addr_i} + (ADDR_W+1)'(1);
    end
  end

  // Write steering: one-cycle registered copy of accepted receiver writes
  always_ff @(posedge rx_clk_i or posedge arst_i) begin
    if (arst_i) begin
      buf_wr_o   <= 1'b0;
      buf_addr_o <= '0;
      buf_data_o <= '0;
    end else begin
      buf_wr_o <= rx_wr_i && slot_free;
      if (rx_wr_i && slot_free) begin
        buf_addr_o <= {wr_ptr, rx_addr_i};
        buf_data_o <= rx_data_i;
      end
    end
  end

  // Descriptor handshake: a descriptor transfers on any cycle where
  // desc_valid_o and desc_ready_i are both high; while valid is high and
  // ready is low the slot/len/crc outputs hold, and valid only falls after
  // a transfer.
  assign desc_valid_o   = (n_full != '0);
  assign desc_slot_o    = dsc_ptr;
  assign desc_len_o     = desc_mem[dsc_ptr].len[ADDR_W:0];
  assign desc_crc_err_o = desc_mem[dsc_ptr].crc_err;
  assign do_pop         = desc_valid_o && desc_ready_i;
  // Only slots already handed to the consumer may be released.
  assign do_rel         = release_i && (n_used > n_full);
  assign dbg_rel_ptr_o  = rel_ptr;

  always_ff @(posedge rx_clk_i or posedge arst_i) begin
    if (arst_i) begin
      wr_ptr  <= '0;
      dsc_ptr <= '0;
      rel_ptr <= '0;
      n_full  <= '0;
      n_used  <= '0;
      for (int i = 0; i < NSLOTS; i++) desc_mem[i] <= '0;
    end else begin
      if (do_accept) begin
        desc_mem[wr_ptr] <= '{len: DESC_LEN_W'(len_q), crc_err: rx_crc_err_i};
        wr_ptr           <= wr_ptr + SLOT_W'(1);
      end
      if (do_pop) dsc_ptr <= dsc_ptr + SLOT_W'(1);
      if (do_rel) rel_ptr <= rel_ptr + SLOT_W'(1);
      n_full <= n_full + (SLOT_W+1)'(do_accept) - (SLOT_W+1)'(do_pop);
      n_used <= n_used + (SLOT_W+1)'(do_accept) - (SLOT_W+1)'(do_rel);
    end
  end

  // Saturating statistics
  iob_reg #(.DATA_W(CNT_W), .RST_VAL({CNT_W{1'b0}})) u_ok_cnt (
    .clk_i  (rx_clk_i),
    .arst_i (arst_i),
    .cke_i  (do_accept && (frames_ok_o != {CNT_W{1'b1}})),
    .data_i (frames_ok_o + CNT_W'(1)),
    .data_o (frames_ok_o)
  );

  iob_reg #(.DATA_W(CNT_W), .RST_VAL({CNT_W{1'b0}})) u_drop_cnt (
    .clk_i  (rx_clk_i),
    .arst_i (arst_i),
    .cke_i  (do_drop && (frames_drop_o != {CNT_W{1'b1}})),
    .data_i (frames_drop_o + CNT_W'(1)),
    .data_o (frames_drop_o)
  );

endmodule
